// File: rtl/serial_cmp_pkg.sv
// Shared types and helpers for the bit-serial comparator sequencer.
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef struct packed {
    logic g;
    logic e;
    logic s;
  } cmp_res_t;

  // Bit counter width: enough to hold WIDTH-1, never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_shreg.sv
// Parallel-in serial-out shift register; bit order chosen by MSB_FIRST.
module serial_shreg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             sout
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  // Load has priority; a shift moves the next bit into the output position.
  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = d;
    end else if (shift) begin
      sr_d = MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);
    end
  end

  // Register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sr_q <= '0;
    else      sr_q <= sr_d;
  end

  assign sout = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];

endmodule

// File: rtl/serial_comp_ctrl.sv
// Sequencer feeding one serial_comp: accepts an operand pair, streams the
// bits, captures the g/e/s flags and hands the result to the consumer.
module serial_comp_ctrl
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_word,
  input  logic [WIDTH-1:0] b_word,
  input  logic             abort,
  output logic             cmp_rst,
  output logic             cmp_a,
  output logic             cmp_b,
  input  logic             cmp_g,
  input  logic             cmp_e,
  input  logic             cmp_s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             res_g,
  output logic             res_e,
  output logic             res_s,
  output logic             busy
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  cmp_res_t      res_q, res_d;

  logic accept;
  logic shifting;
  logic a_bit;
  logic b_bit;

  assign accept   = in_valid && (state_q == IDLE);
  assign shifting = (state_q == SHIFT);

  serial_shreg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_shreg_a (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .shift (shifting),
    .d     (a_word),
    .sout  (a_bit)
  );

  serial_shreg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_shreg_b (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .shift (shifting),
    .d     (b_word),
    .sout  (b_bit)
  );

  // Next-state, counter, result capture and handshake outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    in_ready  = 1'b0;
    cmp_rst   = 1'b0;
    cmp_a     = 1'b0;
    cmp_b     = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        cmp_rst  = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          cnt_d   = CNT_LAST;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        cmp_a = a_bit;
        cmp_b = b_bit;
        if (abort) begin
          // Abort beats the transition out of the last bit.
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = SETTLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      SETTLE: begin
        // Comparator has absorbed the final bit; its flags are valid now.
        if (abort) begin
          state_d = IDLE;
        end else begin
          res_d   = '{g: cmp_g, e: cmp_e, s: cmp_s};
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        cmp_rst   = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter and result registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign res_g = res_q.g;
  assign res_e = res_q.e;
  assign res_s = res_q.s;

endmodule

// File: tb/tb_serial_comp_ctrl.sv
// Bench for serial_comp_ctrl (WIDTH=4, MSB first) with a behavioural
// MSB-first serial comparator and a result scoreboard.
module tb_serial_comp_ctrl;
  import serial_cmp_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] a_word = '0;
  logic [W-1:0] b_word = '0;
  logic         abort = 1'b0;
  logic         out_ready = 1'b1;
  logic         in_ready, cmp_rst, cmp_a, cmp_b, out_valid;
  logic         res_g, res_e, res_s, busy;
  logic         cmp_g = 1'b0;
  logic         cmp_e = 1'b1;
  logic         cmp_s = 1'b0;

  int       checks = 0;
  int       errors = 0;
  cmp_res_t exp_q[$];
  cmp_res_t mon_got;
  cmp_res_t mon_exp;

  always #5 clk = ~clk;

  serial_comp_ctrl #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_word    (a_word),
    .b_word    (b_word),
    .abort     (abort),
    .cmp_rst   (cmp_rst),
    .cmp_a     (cmp_a),
    .cmp_b     (cmp_b),
    .cmp_g     (cmp_g),
    .cmp_e     (cmp_e),
    .cmp_s     (cmp_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res_g     (res_g),
    .res_e     (res_e),
    .res_s     (res_s),
    .busy      (busy)
  );

  // MSB-first serial magnitude comparator: first differing bit decides.
  always @(posedge clk) begin
    if (cmp_rst) begin
      cmp_g <= 1'b0;
      cmp_e <= 1'b1;
      cmp_s <= 1'b0;
    end else if (cmp_e) begin
      if (cmp_a && !cmp_b) begin
        cmp_g <= 1'b1;
        cmp_e <= 1'b0;
      end else if (!cmp_a && cmp_b) begin
        cmp_s <= 1'b1;
        cmp_e <= 1'b0;
      end
    end
  end

  function automatic cmp_res_t ref_cmp(input logic [W-1:0] a, input logic [W-1:0] b);
    cmp_res_t r;
    r.g = (a > b);
    r.e = (a == b);
    r.s = (a < b);
    return r;
  endfunction

  // Scoreboard: every consumed result is popped and compared.
  always @(negedge clk) begin
    #1;
    if (rst && out_valid && out_ready) begin
      mon_got = '{g: res_g, e: res_e, s: res_s};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_unexpected got=%b required=none", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL scoreboard_result got=%b required=%b", mon_got, mon_exp);
        end else begin
          $display("TXN result gsE=%b ok", mon_got);
        end
      end
    end
  end

  // Offer an operand pair (caller is at a negedge); returns at the negedge of cycle 1.
  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    a_word   = a;
    b_word   = b;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL accept_timeout in_ready=%b required=1", in_ready);
    end
    @(posedge clk);
    exp_q.push_back(ref_cmp(a, b));
    $display("TXN accept a=%b b=%b", a, b);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Count cycles (cycle 1 = current negedge) until out_valid, bounded.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL wait_valid_timeout out_valid=%b required=1", out_valid);
    end
  endtask

  task automatic check_res(input string name, input cmp_res_t exp);
    cmp_res_t got;
    got = '{g: res_g, e: res_e, s: res_s};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s res=%b required=%b", name, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    logic [7:0] got;
    got = {in_ready, cmp_rst, cmp_a, cmp_b, out_valid, busy, 2'b00};
    checks++;
    if (got !== 8'b1100_0000) begin
      errors++;
      $display("FAIL %s rdy,crst,a,b,ov,busy=%b required=110000", name, got[7:2]);
    end
  endtask

  task automatic test_reset();
    #2;
    check_idle_outputs("reset_outputs");
    check_res("reset_res", 3'b000);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_reset_idle");
  endtask

  task automatic test_greater();
    int lat;
    accept(4'b0101, 4'b0011);
    checks++;
    if (cmp_rst !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL greater_shift_cmp_rst cmp_rst=%b busy=%b required=0,1", cmp_rst, busy);
    end
    wait_valid(lat);
    checks++;
    if (lat != W + 2) begin
      errors++;
      $display("FAIL greater_latency got=%0d required=%0d", lat, W + 2);
    end
    check_res("greater_res", 3'b100);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL greater_throughput in_ready=%b out_valid=%b required=1,0", in_ready, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    accept(4'b1010, 4'b1010);
    wait_valid(lat);
    check_res("equal_res", 3'b010);
    checks++;
    if (cmp_rst !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done_cmp_rst got=%b required=1", cmp_rst);
    end
    @(negedge clk);
    // Cycle 7: second accept happens at the end of this cycle.
    checks++;
    if (cmp_rst !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle cmp_rst=%b in_ready=%b required=1,1", cmp_rst, in_ready);
    end
    accept(4'b0001, 4'b0100);
    wait_valid(lat);
    checks++;
    if (lat != W + 2) begin
      errors++;
      $display("FAIL b2b_latency got=%0d required=%0d", lat, W + 2);
    end
    check_res("smaller_res", 3'b001);
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    accept(4'b0110, 4'b0010);
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {res_g, res_e, res_s} !== 3'b100) begin
        errors++;
        $display("FAIL backpressure_hold cyc=%0d ov=%b rdy=%b res=%b required=1,0,100",
                 i, out_valid, in_ready, {res_g, res_e, res_s});
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release ov=%b rdy=%b required=0,1", out_valid, in_ready);
    end
  endtask

  task automatic test_abort();
    int lat;
    accept(4'b0000, 4'b1111);
    // Now in first SHIFT cycle; assert abort during the second.
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    void'(exp_q.pop_back());
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || cmp_rst !== 1'b1) begin
      errors++;
      $display("FAIL abort_idle rdy=%b busy=%b crst=%b required=1,0,1", in_ready, busy, cmp_rst);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL abort_no_result cyc=%0d out_valid=%b required=0", i, out_valid);
      end
      @(negedge clk);
    end
    check_res("abort_keeps_res", 3'b100);
    accept(4'b0111, 4'b1000);
    wait_valid(lat);
    check_res("after_abort_res", 3'b001);
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    int lat;
    accept(4'b0011, 4'b0111);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    exp_q.delete();
    check_idle_outputs("async_reset_outputs");
    check_res("async_reset_res", 3'b000);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    accept(4'b1111, 4'b1110);
    wait_valid(lat);
    check_res("post_reset_res", 3'b100);
    @(negedge clk);
  endtask

  task automatic test_ignored_input();
    int lat;
    accept(4'b0010, 4'b1000);
    in_valid = 1'b1;
    a_word   = 4'b1111;
    b_word   = 4'b0000;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ignored_in_ready got=%b required=0", in_ready);
    end
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(lat);
    check_res("ignored_input_res", 3'b001);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ignored_no_extra ov=%b busy=%b required=0,0", out_valid, busy);
    end
  endtask

  initial begin
    test_reset();
    test_greater();
    test_back_to_back();
    test_backpressure();
    test_abort();
    test_async_reset();
    test_ignored_input();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
